inst_rom: RTL and testbench
===========================

# inst_rom

Instruction memory responder for the fetch port of the `openmips` core.
- Serves `o_inst_data` combinationally from `i_inst_addr`/`i_inst_ren`, so the core's `if_id` register captures the word on the next edge.
- Program contents enter through a byte-stream loader: an FSM that assembles big-endian words and writes them sequentially.
- Fetches are masked to NOP (32'h0) until a load completes.

## Interface
- `DEPTH_LOG2`, default 10: memory holds 2^DEPTH_LOG2 32-bit words.
- `i_clk`  in  1  system clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `i_inst_ren`  in  1  fetch enable, driven by the core's `o_inst_ren`.
- `i_inst_addr`  in  `N_INST_ADDR`  byte address; word index = `i_inst_addr[DEPTH_LOG2+1:2]`.
- `o_inst_data`  out  `N_INST_DATA`  fetched instruction word (combinational).
- `i_ld_start`  in  1  single-cycle pulse: begin or restart a program load.
- `i_ld_valid`  in  1  loader byte valid.
- `i_ld_byte`  in  8  loader byte.
- `i_ld_last`  in  1  qualifies the final byte of the program.
- `o_ld_ready`  out  1  loader can accept a byte.
- `o_ld_busy`  out  1  FSM is in LOAD.
- `o_ld_done`  out  1  FSM is in DONE; fetch is live.
- `o_ld_words`  out  `DEPTH_LOG2+1`  number of words written by the last or current load.
- `o_ld_full`  out  1  the last load was terminated because memory filled.

## Operation
- FSM states: IDLE, LOAD, DONE. Reset state is IDLE.
- IDLE/DONE → LOAD when `i_ld_start` is high. On entry, clear the byte lane, `o_ld_words` and `o_ld_full`.
- `i_ld_start` in LOAD restarts the load with the same clears. The start cycle never accepts a byte.
- LOAD:
  - `o_ld_ready` = 1; a byte is accepted when `i_ld_valid && o_ld_ready`.
  - Bytes fill lanes big-endian: the first byte goes to [31:24], the fourth to [7:0].
  - The 4th accepted byte writes the assembled word to mem[`o_ld_words`], increments `o_ld_words`, and resets the lane to 0.
- An accepted byte with `i_ld_last` = 1 → DONE.
  - If the word is partial, unfilled lanes are 0, it is written, and `o_ld_words` increments.
  - If `i_ld_last` arrives with `i_ld_valid` = 0, it is ignored.
- Full memory: when the word written makes `o_ld_words` = 2^DEPTH_LOG2 → DONE and `o_ld_full` = 1, even if `i_ld_last` = 0.
- Fetch output:
  - `o_inst_data` = mem[index] only when state = DONE and `i_inst_ren` = 1; otherwise 32'h0.
  - Address bits [1:0] are ignored.
- Memory array is not reset. Contents survive `i_rst_n` but are masked until the next completed load.
- Reset mid-load:
  - FSM → IDLE; lane, `o_ld_words` and `o_ld_full` clear.
  - Words already written stay in the array.

## Timing
- Reset values: `o_inst_data` 0, `o_ld_ready` 0, `o_ld_busy` 0, `o_ld_done` 0, `o_ld_words` 0, `o_ld_full` 0.
- Fetch latency is 0 cycles (combinational from address/enable/state).
- `o_ld_ready` and `o_ld_busy` rise the cycle after the `i_ld_start` edge.
- Completing byte accepted at edge N:
  - The memory write lands at edge N.
  - DONE and `o_ld_done` are visible after edge N, so a fetch of the last word is correct in cycle N+1.
- Minimum load time is 4·W + 1 cycles for W full words at 100% valid duty.
- Simultaneous `i_ld_start` and `i_ld_valid`: start wins and the byte is dropped.

## Configuration
- `INST_ROM_ADDR_CHECK_EN` defined:
  - A fetch whose word address ≥ `o_ld_words`, or whose `i_inst_addr` bits above DEPTH_LOG2+1 are nonzero, returns 32'h0.
  - The core runs off the end of the program into NOPs.
- Undefined:
  - Upper address bits are ignored (the index wraps modulo depth).
  - Unloaded locations return raw array contents.

## Test plan
- Reset, no load; fetch addr 0x0 with ren = 1 → `o_inst_data` = 0, `o_ld_done` = 0.
- Start, then bytes 34,01,11,00 (last on 4th) → mem[0] = 32'h34011100; `o_ld_words` = 1; DONE next cycle; fetch 0x0 → 32'h34011100.
- Start; 6 bytes AA..FF, last on 6th → word0 = 32'hAABBCCDD, word1 = 32'hEEFF0000, `o_ld_words` = 2.
- DEPTH_LOG2 = 2, 16 bytes, no last → `o_ld_full` = 1 and DONE after the 16th byte; a 17th byte sees `o_ld_ready` = 0.
- Reset asserted after 5 bytes → IDLE, `o_ld_words` = 0, fetch returns 0; reload succeeds.
- With `INST_ROM_ADDR_CHECK_EN`, 2 words loaded → fetch 0x8 returns 0; fetch 0x4 returns word1.

Source files
------------

// File: rtl/inst_rom.sv
// inst_rom: instruction memory for the openmips fetch port.
// A byte-stream loader FSM (IDLE/LOAD/DONE) assembles big-endian words and
// writes them sequentially; fetches return 32'h0 until a load completes.
// Optional macro INST_ROM_ADDR_CHECK_EN: fetches beyond the loaded program or
// with nonzero upper address bits return 32'h0.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_inst_ren, i_inst_addr   fetch enable / byte address
//   o_inst_data               fetched word (combinational)
//   i_ld_start                begin or restart a load (pulse)
//   i_ld_valid/i_ld_byte/i_ld_last  loader byte stream
//   o_ld_ready, o_ld_busy     loader accepting bytes / in LOAD
//   o_ld_done                 load complete, fetch live
//   o_ld_words, o_ld_full     words written / load ended on full memory
module inst_rom #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned N_INST_ADDR = 32,
  parameter int unsigned N_INST_DATA = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_inst_ren,
  input  logic [N_INST_ADDR-1:0] i_inst_addr,
  output logic [N_INST_DATA-1:0] o_inst_data,
  input  logic                   i_ld_start,
  input  logic                   i_ld_valid,
  input  logic [7:0]             i_ld_byte,
  input  logic                   i_ld_last,
  output logic                   o_ld_ready,
  output logic                   o_ld_busy,
  output logic                   o_ld_done,
  output logic [DEPTH_LOG2:0]    o_ld_words,
  output logic                   o_ld_full
);

  localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             lane_q, lane_d;
  logic [WORD_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]       words_q, words_d;
  logic                   full_q, full_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   we_c;
  logic [WORD_W-1:0]      word_c;
  logic [CNT_W-1:0]       words_inc_c;

  logic [N_INST_DATA-1:0] mem [DEPTH];

  // Merge the incoming byte into the partially assembled word, big-endian.
  always_comb begin
    word_c = '0;
    unique case (lane_q)
      2'd0:    word_c = {i_ld_byte, 24'h0};
      2'd1:    word_c = {acc_q[31:24], i_ld_byte, 16'h0};
      2'd2:    word_c = {acc_q[31:16], i_ld_byte, 8'h0};
      default: word_c = {acc_q[31:8], i_ld_byte};
    endcase
  end

  assign words_inc_c = words_q + CNT_W'(1);

  // Loader next-state logic.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    acc_d   = acc_q;
    words_d = words_q;
    full_d  = full_q;
    we_c    = 1'b0;

    if (i_ld_start) begin
      // Start (or restart) always wins over a concurrent byte.
      state_d = ST_LOAD;
      lane_d  = 2'd0;
      acc_d   = '0;
      words_d = '0;
      full_d  = 1'b0;
    end else if (state_q == ST_LOAD && i_ld_valid) begin
      if (lane_q == 2'd3 || i_ld_last) begin
        we_c    = 1'b1;
        words_d = words_inc_c;
        lane_d  = 2'd0;
        acc_d   = '0;
        if (i_ld_last) begin
          state_d = ST_DONE;
        end
        if (words_inc_c == CNT_W'(DEPTH)) begin
          state_d = ST_DONE;
          full_d  = 1'b1;
        end
      end else begin
        acc_d  = word_c;
        lane_d = lane_q + 2'd1;
      end
    end

    busy_d = (state_d == ST_LOAD);
    done_d = (state_d == ST_DONE);
  end

  // Loader state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      lane_q  <= 2'd0;
      acc_q   <= '0;
      words_q <= '0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      words_q <= words_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Program store; deliberately not reset so contents survive i_rst_n.
  always_ff @(posedge i_clk) begin
    if (we_c) begin
      mem[words_q[DEPTH_LOG2-1:0]] <= N_INST_DATA'(word_c);
    end
  end

  assign o_ld_ready = busy_q;
  assign o_ld_busy  = busy_q;
  assign o_ld_done  = done_q;
  assign o_ld_words = words_q;
  assign o_ld_full  = full_q;

  // Fetch path.
  logic [DEPTH_LOG2-1:0] fetch_idx;
  logic                  fetch_ok_c;
  logic                  unused_addr;

  assign fetch_idx   = i_inst_addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^i_inst_addr;

`ifdef INST_ROM_ADDR_CHECK_EN
  assign fetch_ok_c = ((i_inst_addr >> (DEPTH_LOG2 + 2)) == '0) &&
                      ({1'b0, fetch_idx} < words_q);
`else
  assign fetch_ok_c = 1'b1;
`endif

  assign o_inst_data = (done_q && i_inst_ren && fetch_ok_c) ? mem[fetch_idx] : '0;

endmodule

// File: tb/tb_inst_rom.sv
module tb_inst_rom;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Main instance (DEPTH_LOG2 = 10)
  logic        ren = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data;
  logic        start = 1'b0, valid = 1'b0, last = 1'b0;
  logic [7:0]  bval = '0;
  logic        ready, busy, done, full;
  logic [10:0] words;

  // Small instance (DEPTH_LOG2 = 2)
  logic        s_ren = 1'b0;
  logic [31:0] s_addr = '0;
  logic [31:0] s_data;
  logic        s_start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [7:0]  s_bval = '0;
  logic        s_ready, s_busy, s_done, s_full;
  logic [2:0]  s_words;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_rom #(.DEPTH_LOG2(10)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst_ren(ren), .i_inst_addr(addr),
    .o_inst_data(data), .i_ld_start(start), .i_ld_valid(valid),
    .i_ld_byte(bval), .i_ld_last(last), .o_ld_ready(ready), .o_ld_busy(busy),
    .o_ld_done(done), .o_ld_words(words), .o_ld_full(full)
  );

  inst_rom #(.DEPTH_LOG2(2)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst_ren(s_ren), .i_inst_addr(s_addr),
    .o_inst_data(s_data), .i_ld_start(s_start), .i_ld_valid(s_valid),
    .i_ld_byte(s_bval), .i_ld_last(s_last), .o_ld_ready(s_ready), .o_ld_busy(s_busy),
    .o_ld_done(s_done), .o_ld_words(s_words), .o_ld_full(s_full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    valid = 1'b1; bval = b; last = l;
    tick();
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic send_byte_s(input logic [7:0] b, input logic l);
    s_valid = 1'b1; s_bval = b; s_last = l;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    ren = 1'b1; addr = 32'h0;
    #1;
    checks++; if (data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", data, 32'h0); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if ({ready, busy, full} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {ready, busy, full}); end
    checks++; if (words !== 11'd0) begin failures++; $display("FAIL reset_words got=%0d exp=0", words); end
    rst_n = 1'b1;
    tick();
    checks++; if (data !== 32'h0 || done !== 1'b0) begin failures++; $display("FAIL idle_fetch got=%h/%b exp=0/0", data, done); end
  endtask

  task automatic test_single_word();
    pulse_start();
    checks++; if ({ready, busy} !== 2'b11) begin failures++; $display("FAIL start_ready got=%b exp=11", {ready, busy}); end
    send_byte(8'h34, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    checks++; if (done !== 1'b0 || words !== 11'd0) begin failures++; $display("FAIL single_mid got=%b/%0d exp=0/0", done, words); end
    send_byte(8'h00, 1'b1);
    checks++; if (words !== 11'd1) begin failures++; $display("FAIL single_words got=%0d exp=1", words); end
    checks++; if ({done, busy, ready} !== 3'b100) begin failures++; $display("FAIL single_state got=%b exp=100", {done, busy, ready}); end
    addr = 32'h0; ren = 1'b1; #1;
    checks++; if (data !== 32'h34011100) begin failures++; $display("FAIL single_fetch got=%h exp=34011100", data); end
  endtask

  task automatic test_partial_word();
    pulse_start();
    checks++; if (words !== 11'd0 || done !== 1'b0) begin failures++; $display("FAIL partial_clear got=%0d/%b exp=0/0", words, done); end
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hFF, 1'b1);
    checks++; if (words !== 11'd2 || done !== 1'b1) begin failures++; $display("FAIL partial_words got=%0d/%b exp=2/1", words, done); end
    ren = 1'b1; addr = 32'h0; #1;
    checks++; if (data !== 32'hAABBCCDD) begin failures++; $display("FAIL partial_w0 got=%h exp=AABBCCDD", data); end
    addr = 32'h4; #1;
    checks++; if (data !== 32'hEEFF0000) begin failures++; $display("FAIL partial_w1 got=%h exp=EEFF0000", data); end
    addr = 32'h7; #1;
    checks++; if (data !== 32'hEEFF0000) begin failures++; $display("FAIL partial_lowbits got=%h exp=EEFF0000", data); end
    ren = 1'b0; #1;
    checks++; if (data !== 32'h0) begin failures++; $display("FAIL partial_ren0 got=%h exp=0", data); end
    ren = 1'b1;
  endtask

  task automatic test_back_to_back();
    pulse_start();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    checks++; if (words !== 11'd1) begin failures++; $display("FAIL b2b_pre got=%0d exp=1", words); end
    // Restart with a concurrent byte: byte must be dropped.
    start = 1'b1; valid = 1'b1; bval = 8'h99;
    tick();
    start = 1'b0; valid = 1'b0;
    checks++; if (words !== 11'd0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_restart got=%0d/%b exp=0/1", words, busy); end
    // Last without valid is ignored.
    last = 1'b1;
    tick();
    last = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_last_novalid got=%b/%b exp=1/0", busy, done); end
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    addr = 32'h0; #1;
    checks++; if (data !== 32'h01020304 || words !== 11'd1) begin failures++; $display("FAIL b2b_fetch got=%h/%0d exp=01020304/1", data, words); end
  endtask

  task automatic test_full();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 15; i++) send_byte_s(8'(i + 1), 1'b0);
    checks++; if (s_done !== 1'b0 || s_busy !== 1'b1 || s_words !== 3'd3) begin failures++; $display("FAIL full_pre got=%b/%b/%0d exp=0/1/3", s_done, s_busy, s_words); end
    send_byte_s(8'd16, 1'b0);
    checks++; if (s_full !== 1'b1 || s_done !== 1'b1 || s_words !== 3'd4) begin failures++; $display("FAIL full_flag got=%b/%b/%0d exp=1/1/4", s_full, s_done, s_words); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", s_ready); end
    send_byte_s(8'hEE, 1'b0);
    checks++; if (s_words !== 3'd4 || s_done !== 1'b1) begin failures++; $display("FAIL full_17th got=%0d/%b exp=4/1", s_words, s_done); end
    s_ren = 1'b1; s_addr = 32'hC; #1;
    checks++; if (s_data !== 32'h0D0E0F10) begin failures++; $display("FAIL full_w3 got=%h exp=0D0E0F10", s_data); end
    s_addr = 32'h0; #1;
    checks++; if (s_data !== 32'h01020304) begin failures++; $display("FAIL full_w0 got=%h exp=01020304", s_data); end
  endtask

  task automatic test_reset_mid_load();
    // Reload two words so mem[1] holds a known value before the aborted load.
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(8'h60 + 8'(i), (i == 7));
    pulse_start();
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    send_byte(8'hA4, 1'b0);
    send_byte(8'hA5, 1'b0);
    rst_n = 1'b0; #1;
    checks++; if (words !== 11'd0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_mid_state got=%0d/%b/%b exp=0/0/0", words, busy, done); end
    addr = 32'h0; ren = 1'b1; #1;
    checks++; if (data !== 32'h0) begin failures++; $display("FAIL rst_mid_fetch got=%h exp=0", data); end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_byte(8'hC0, 1'b0);
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b1);
    addr = 32'h0; #1;
    checks++; if (data !== 32'hC0C1C2C3 || words !== 11'd1) begin failures++; $display("FAIL rst_reload got=%h/%0d exp=C0C1C2C3/1", data, words); end
    addr = 32'h4; #1;
`ifdef INST_ROM_ADDR_CHECK_EN
    checks++; if (data !== 32'h0) begin failures++; $display("FAIL rst_unloaded got=%h exp=0", data); end
`else
    checks++; if (data !== 32'h64656667) begin failures++; $display("FAIL rst_survive got=%h exp=64656667", data); end
`endif
  endtask

  task automatic test_addr_check();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), (i == 7));
    checks++; if (words !== 11'd2) begin failures++; $display("FAIL ac_words got=%0d exp=2", words); end
    addr = 32'h4; #1;
    checks++; if (data !== 32'h14151617) begin failures++; $display("FAIL ac_w1 got=%h exp=14151617", data); end
    addr = 32'h1004; #1;
`ifdef INST_ROM_ADDR_CHECK_EN
    checks++; if (data !== 32'h0) begin failures++; $display("FAIL ac_upper got=%h exp=0", data); end
    addr = 32'h8; #1;
    checks++; if (data !== 32'h0) begin failures++; $display("FAIL ac_beyond got=%h exp=0", data); end
`else
    checks++; if (data !== 32'h14151617) begin failures++; $display("FAIL ac_wrap got=%h exp=14151617", data); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_partial_word();
    test_back_to_back();
    test_full();
    test_reset_mid_load();
    test_addr_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
